// File: rtl/decoding_stage_controller_if.sv
// Host/array-facing bundle of the decoding stage controller: start/done
// handshakes, aggregated busy/odd flags, stage broadcast and round statistics.
interface decoding_stage_controller_if #(
  parameter int PU_COUNT    = 64,
  parameter int STAGE_WIDTH = 3,
  parameter int ITER_WIDTH  = 8,
  parameter int CYCLE_WIDTH = 16
);
  logic                   start_valid;
  logic                   start_ready;
  logic [PU_COUNT-1:0]    busy;
  logic [PU_COUNT-1:0]    odd;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   done_valid;
  logic                   done_ready;
  logic                   timeout;
  logic [ITER_WIDTH-1:0]  iteration_count;
  logic [CYCLE_WIDTH-1:0] cycle_count;

  modport master (
    output start_valid, busy, odd, done_ready,
    input  start_ready, global_stage, done_valid, timeout, iteration_count, cycle_count
  );

  modport slave (
    input  start_valid, busy, odd, done_ready,
    output start_ready, global_stage, done_valid, timeout, iteration_count, cycle_count
  );
endinterface

// File: rtl/decoding_stage_controller.sv
// Sequencer for one decoding round: load, alternating merge/grow until no odd
// cluster remains (or the iteration limit hits), peel, then report.
module decoding_stage_controller #(
  parameter int PU_COUNT      = 64,
  parameter int STAGE_WIDTH   = 3,
  parameter int LOAD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int BUSY_PIPE     = 0,
  parameter int MAX_ITER      = 31,
  parameter int ITER_WIDTH    = 8,
  parameter int CYCLE_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  decoding_stage_controller_if.slave bus
);
  localparam logic [STAGE_WIDTH-1:0] ST_IDLE   = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] ST_GROW   = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] ST_MERGE  = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] ST_PEEL   = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] ST_LOAD   = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] ST_REPORT = STAGE_WIDTH'(5);

  localparam int CNT_MAX = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]      LOAD_INIT   = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [ITER_WIDTH-1:0] ITER_MAX    = ITER_WIDTH'(MAX_ITER);

  logic busy_any, odd_any;

  generate
    if (BUSY_PIPE == 0) begin : g_nopipe
      assign busy_any = |bus.busy;
      assign odd_any  = |bus.odd;
    end else begin : g_pipe
      logic [BUSY_PIPE-1:0] busy_pipe_q, odd_pipe_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          busy_pipe_q <= '0;
          odd_pipe_q  <= '0;
        end else begin
          busy_pipe_q[0] <= |bus.busy;
          odd_pipe_q[0]  <= |bus.odd;
          for (int i = 1; i < BUSY_PIPE; i++) begin
            busy_pipe_q[i] <= busy_pipe_q[i-1];
            odd_pipe_q[i]  <= odd_pipe_q[i-1];
          end
        end
      end
      assign busy_any = busy_pipe_q[BUSY_PIPE-1];
      assign odd_any  = odd_pipe_q[BUSY_PIPE-1];
    end
  endgenerate

  logic [STAGE_WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ITER_WIDTH-1:0]  iter_q, iter_d;
  logic [CYCLE_WIDTH-1:0] cyc_q, cyc_d;
  logic                   timeout_q, timeout_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      iter_q    <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iter_q    <= iter_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  // cnt_q serves as the LOADING hold timer and as the MERGE/PEELING settle
  // timer; busy/odd are only looked at once it has drained to zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iter_d    = iter_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    if ((state_q == ST_LOAD || state_q == ST_MERGE || state_q == ST_GROW ||
         state_q == ST_PEEL) && cyc_q != '1)
      cyc_d = cyc_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          state_d   = ST_LOAD;
          cnt_d     = LOAD_INIT;
          iter_d    = '0;
          cyc_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == '0) begin
          state_d = ST_MERGE;
          cnt_d   = SETTLE_INIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_MERGE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!busy_any) begin
          if (!odd_any) begin
            state_d = ST_PEEL;
            cnt_d   = SETTLE_INIT;
          end else if (iter_q == ITER_MAX) begin
            state_d   = ST_REPORT;
            timeout_d = 1'b1;
          end else begin
            state_d = ST_GROW;
            iter_d  = iter_q + 1'b1;
          end
        end
      end
      ST_GROW: begin
        state_d = ST_MERGE;
        cnt_d   = SETTLE_INIT;
      end
      ST_PEEL: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (!busy_any) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (bus.done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.global_stage    = state_q;
    bus.start_ready     = (state_q == ST_IDLE);
    bus.done_valid      = (state_q == ST_REPORT);
    bus.timeout         = timeout_q;
    bus.iteration_count = iter_q;
    bus.cycle_count     = cyc_q;
  end
endmodule

// File: tb/tb_decoding_stage_controller.sv
// Drives directed and random decoding rounds and compares the stage trace and
// statistics against a schedule built from the round's merge/peel scenario.
module tb_decoding_stage_controller;
  localparam int PU     = 64;
  localparam int LOAD   = 2;
  localparam int SETTLE = 3;
  localparam int MAXIT  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  decoding_stage_controller_if #(.PU_COUNT(PU), .STAGE_WIDTH(3), .ITER_WIDTH(8), .CYCLE_WIDTH(16)) bus ();

  decoding_stage_controller #(
    .PU_COUNT(PU), .STAGE_WIDTH(3), .LOAD_CYCLES(LOAD), .SETTLE_CYCLES(SETTLE),
    .BUSY_PIPE(0), .MAX_ITER(MAXIT), .ITER_WIDTH(8), .CYCLE_WIDTH(16)
  ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0, passes = 0, fails = 0;
  int m_odd[8];
  int m_ext[8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 0: all clear, 1: one random flag set, 2: don't-care (random garbage)
  function automatic logic [PU-1:0] pat(input int code);
    logic [PU-1:0] v;
    if (code == 0) v = '0;
    else if (code == 1) v = {{(PU-1){1'b0}}, 1'b1} << $urandom_range(0, PU-1);
    else v = {$urandom, $urandom};
    return v;
  endfunction

  task automatic clear_scn();
    for (int i = 0; i < 8; i++) begin m_odd[i] = 0; m_ext[i] = 0; end
  endtask

  // Builds the expected per-cycle stage trace from the scenario, drives it,
  // then checks REPORT statistics, backpressure and the return to IDLE.
  // rst_at >= 0 pulls reset that many cycles into PEELING instead.
  task automatic run_round(input int peel_ext, input int bp, input int rst_at);
    int st[$], bz[$], od[$];
    int iter = 0, to = 0, peel_start = -1, ncyc;
    for (int j = 0; j < LOAD; j++) begin st.push_back(4); bz.push_back(2); od.push_back(2); end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < SETTLE; j++) begin st.push_back(2); bz.push_back(2); od.push_back(2); end
      for (int j = 0; j < m_ext[i]; j++) begin st.push_back(2); bz.push_back(1); od.push_back(2); end
      st.push_back(2); bz.push_back(0); od.push_back(m_odd[i] != 0 ? 1 : 0);
      if (m_odd[i] == 0) break;
      if (iter == MAXIT) begin to = 1; break; end
      iter++;
      st.push_back(1); bz.push_back(2); od.push_back(2);
    end
    if (to == 0) begin
      peel_start = st.size();
      for (int j = 0; j < SETTLE; j++) begin st.push_back(3); bz.push_back(2); od.push_back(2); end
      for (int j = 0; j < peel_ext; j++) begin st.push_back(3); bz.push_back(1); od.push_back(2); end
      st.push_back(3); bz.push_back(0); od.push_back(2);
    end
    ncyc = st.size();

    chk("idle_start_ready", 64'(bus.start_ready), 64'd1);
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      bus.busy = pat(bz[t]);
      bus.odd  = pat(od[t]);
      bus.start_valid = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      chk($sformatf("stage[%0d]", t), 64'(bus.global_stage), 64'(st[t]));
      if (rst_at >= 0 && t == peel_start + rst_at) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_stage", 64'(bus.global_stage), 64'd0);
        chk("rst_start_ready", 64'(bus.start_ready), 64'd1);
        chk("rst_done_valid", 64'(bus.done_valid), 64'd0);
        bus.start_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold_done_valid", 64'(bus.done_valid), 64'd0);
        end
        reset_n = 1'b1;
        #1;
        chk("rst_iter", 64'(bus.iteration_count), 64'd0);
        chk("rst_cycles", 64'(bus.cycle_count), 64'd0);
        chk("rst_timeout", 64'(bus.timeout), 64'd0);
        return;
      end
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;
    bus.busy = pat(2);
    bus.odd  = pat(2);
    @(negedge clk);
    chk("report_stage", 64'(bus.global_stage), 64'd5);
    chk("done_valid", 64'(bus.done_valid), 64'd1);
    chk("start_ready_busy", 64'(bus.start_ready), 64'd0);
    chk("timeout", 64'(bus.timeout), 64'(to));
    chk("iteration_count", 64'(bus.iteration_count), 64'(iter));
    chk("cycle_count", 64'(bus.cycle_count), 64'(ncyc));
    for (int k = 0; k < bp; k++) begin
      bus.start_valid = 1'b1;
      bus.busy = pat(2);
      @(posedge clk);
      @(negedge clk);
      chk("bp_stage", 64'(bus.global_stage), 64'd5);
      chk("bp_iter", 64'(bus.iteration_count), 64'(iter));
      chk("bp_cycles", 64'(bus.cycle_count), 64'(ncyc));
      chk("bp_timeout", 64'(bus.timeout), 64'(to));
    end
    bus.start_valid = 1'b0;
    bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    @(negedge clk);
    chk("back_idle_stage", 64'(bus.global_stage), 64'd0);
    chk("back_idle_done_valid", 64'(bus.done_valid), 64'd0);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b0;
    bus.busy = '0;
    bus.odd  = '0;
    #12;
    chk("reset_stage", 64'(bus.global_stage), 64'd0);
    chk("reset_start_ready", 64'(bus.start_ready), 64'd1);
    chk("reset_done_valid", 64'(bus.done_valid), 64'd0);
    chk("reset_timeout", 64'(bus.timeout), 64'd0);
    chk("reset_iter", 64'(bus.iteration_count), 64'd0);
    chk("reset_cycles", 64'(bus.cycle_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // zero syndrome: 4,4,2,2,2,2,3,3,3,3,5 with cycle_count 10
    clear_scn();
    run_round(0, 0, -1);
    // single grow between two merges
    clear_scn(); m_odd[0] = 1;
    run_round(0, 0, -1);
    // busy held 5 cycles past settle in the first merge
    clear_scn(); m_ext[0] = 5;
    run_round(0, 0, -1);
    // odd never clears: MAXIT grows then timeout
    clear_scn(); for (int i = 0; i < 8; i++) m_odd[i] = 1;
    run_round(0, 0, -1);
    // backpressure with start_valid held during REPORT
    clear_scn(); m_odd[0] = 1; m_ext[1] = 2;
    run_round(2, 10, -1);

    for (int r = 0; r < 12; r++) begin
      int n_odd;
      clear_scn();
      n_odd = $urandom_range(0, MAXIT + 1);
      for (int i = 0; i < 8; i++) begin
        m_odd[i] = (i < n_odd) ? 1 : 0;
        m_ext[i] = $urandom_range(0, 4);
      end
      run_round($urandom_range(0, 4), $urandom_range(0, 3), -1);
    end

    // reset two cycles into PEELING, then a clean round afterwards
    clear_scn(); m_odd[0] = 1;
    run_round(3, 0, 2);
    @(negedge clk);
    clear_scn();
    run_round(0, 0, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
